// File: rtl/instr_loader_pkg.sv
// Shared definitions for the program loader and the halt-detection logic.
// Holds the HALT opcode, the opcode field bounds and the loader FSM encoding.
package instr_loader_pkg;

    localparam int         MEM_DEPTH_DEFAULT = 32;
    localparam int         OPCODE_MSB        = 31;
    localparam int         OPCODE_LSB        = 26;
    localparam logic [5:0] HALT_OPCODE       = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs received bytes MSB-first into instruction words.
// o_word_ready pulses combinationally in the cycle the fourth byte is presented.
module word_assembler #(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_enable,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_word,
    output logic                  o_word_ready
);

    logic [DATA_WIDTH-BYTE_WIDTH-1:0] shift;
    logic [1:0]                       byte_cnt;
    logic                             accept;

    assign accept       = i_enable && i_rx_valid;
    assign o_word       = {shift, i_rx_data};
    assign o_word_ready = accept && (byte_cnt == 2'd3);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            shift    <= '0;
            byte_cnt <= 2'd0;
        end else if (i_clear) begin
            shift    <= '0;
            byte_cnt <= 2'd0;
        end else if (accept) begin
            shift    <= o_word[DATA_WIDTH-BYTE_WIDTH-1:0];
            byte_cnt <= byte_cnt + 2'd1;  // wraps 3 -> 0 on the word boundary
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Program-load controller: packs the serial byte stream into words and writes them
// to consecutive instruction-memory addresses until HALT or memory overflow.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | after reset, waiting for i_start
//  ST_RECV  | collecting bytes of the current word
//  ST_WRITE | one-cycle memory write of the assembled word
//  ST_DONE  | HALT word written, o_done held until next i_start
//  ST_ERROR | MEM_DEPTH words written without HALT, o_error held
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int MEM_DEPTH  = MEM_DEPTH_DEFAULT,
    parameter int SIZEOP     = OPCODE_MSB - OPCODE_LSB + 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [BYTE_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_write,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_words
);

    localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(MEM_DEPTH - 1);

    state_t                  state, state_nxt;
    logic                    load_start;
    logic                    asm_enable;
    logic [DATA_WIDTH-1:0]   asm_word;
    logic                    asm_ready;
    logic                    is_halt;
    logic                    at_last;

    assign asm_enable = (state == ST_RECV) || (state == ST_WRITE);
    assign is_halt    = (o_instruccion[DATA_WIDTH-1 -: SIZEOP] == SIZEOP'(HALT_OPCODE));
    assign at_last    = (o_address == LAST_ADDR);

    word_assembler #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_word_assembler (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (load_start),
        .i_enable     (asm_enable),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_word       (asm_word),
        .o_word_ready (asm_ready)
    );

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_nxt  = ST_RECV;
                    load_start = 1'b1;
                end
            end
            ST_RECV: begin
                if (asm_ready) state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (is_halt)      state_nxt = ST_DONE;
                else if (at_last) state_nxt = ST_ERROR;
                else              state_nxt = ST_RECV;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address and instruction only move outside ST_WRITE, so a level-sensitive memory
    // never sees a half-updated word while o_write is high.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            o_address     <= '0;
            o_words       <= '0;
            o_instruccion <= '0;
        end else begin
            if (load_start) begin
                o_address <= '0;
                o_words   <= '0;
            end
            if ((state == ST_RECV) && asm_ready) begin
                o_instruccion <= asm_word;
            end
            if (state == ST_WRITE) begin
                o_words <= o_words + 1'b1;
                if (!is_halt && !at_last) o_address <= o_address + 1'b1;
            end
        end
    end

    always_comb begin
        o_write = (state == ST_WRITE);
        o_busy  = (state == ST_RECV) || (state == ST_WRITE);
        o_done  = (state == ST_DONE);
        o_error = (state == ST_ERROR);
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader: the driver pushes expected memory
// writes from a word-level program model, an independent monitor pops and compares.
module tb_instr_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        o_write;
    logic [31:0] o_address;
    logic [31:0] o_instruccion;
    logic        o_busy;
    logic        o_done;
    logic        o_error;
    logic [31:0] o_words;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    // Program model: words land at consecutive addresses from 0, loading stops after
    // a word whose top six bits are all ones, or after the word written at address 31.
    bit          m_loading, m_done, m_error;
    int          m_addr, m_words, m_nbytes;
    logic [31:0] m_word;

    instr_loader dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_rx_data     (rx_data),
        .i_rx_valid    (rx_valid),
        .o_write       (o_write),
        .o_address     (o_address),
        .o_instruccion (o_instruccion),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_words       (o_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (o_write !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: o_write=%b addr=0x%08h data=0x%08h at %0t",
                         o_write, o_address, o_instruccion, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", o_address, e.addr);
                chk("wr_data", o_instruccion, e.data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_loading = 0; m_done = 0; m_error = 0;
        m_addr = 0; m_words = 0; m_nbytes = 0; m_word = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        if (!m_loading) begin
            model_reset();
            m_loading = 1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        if (m_loading) begin
            m_word = (m_word << 8) | {24'd0, b};
            m_nbytes++;
            if (m_nbytes == 4) begin
                exp_q.push_back('{32'(m_addr), m_word});
                m_nbytes = 0;
                m_words++;
                if (m_word[31:26] == 6'h3F) begin
                    m_loading = 0; m_done = 1;
                end else if (m_addr == 31) begin
                    m_loading = 0; m_error = 1;
                end else begin
                    m_addr++;
                end
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(v[31:24]);
            v = v << 8;
            if (maxgap > 0) idle($urandom_range(maxgap));
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        idle(2);
    endtask

    task automatic check_status(input string name);
        chk({name, "_done"},  {31'd0, o_done},  {31'd0, m_done});
        chk({name, "_error"}, {31'd0, o_error}, {31'd0, m_error});
        chk({name, "_busy"},  {31'd0, o_busy},  {31'd0, m_loading});
        chk({name, "_words"}, o_words, 32'(m_words));
        chk({name, "_addr"},  o_address, 32'(m_addr));
    endtask

    function automatic logic [31:0] rand_nonhalt();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    function automatic logic [31:0] rand_halt();
        logic [31:0] w;
        w = $urandom;
        w[31:26] = 6'h3F;
        return w;
    endfunction

    initial begin
        rst_n = 1'b0; start = 1'b0; rx_data = '0; rx_valid = 1'b0;
        model_reset();
        idle(3);
        check_status("reset");
        chk("reset_instr", o_instruccion, 32'd0);
        chk("reset_write", {31'd0, o_write}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // bytes ignored while idle
        send_word(32'h12345678, 0);
        idle(2);
        check_status("idle_bytes");

        // two-word program ending in HALT
        pulse_start();
        chk("load_busy", {31'd0, o_busy}, 32'd1);
        foreach (exp_q[i]) ;
        send_byte(8'h20); send_byte(8'h01); idle(1); send_byte(8'h00); send_byte(8'h05);
        idle(2);
        send_byte(8'hFC); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        drain("prog2");
        check_status("prog2");

        // reset in the middle of a word aborts to idle with no write
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB);
        rst_n = 1'b0;
        model_reset();
        idle(2);
        check_status("midreset");
        chk("midreset_instr", o_instruccion, 32'd0);
        rst_n = 1'b1;
        idle(2);
        check_status("after_reset");

        // back-to-back bytes across the write cycles
        pulse_start();
        for (int i = 0; i < 3; i++) send_word(rand_nonhalt(), 0);
        send_word(rand_halt(), 0);
        drain("b2b");
        check_status("b2b");

        // i_start during RECV is ignored
        pulse_start();
        begin
            logic [31:0] w;
            w = rand_nonhalt();
            send_byte(w[31:24]); send_byte(w[23:16]);
            pulse_start();
            send_byte(w[15:8]); send_byte(w[7:0]);
        end
        send_word(rand_halt(), 1);
        drain("start_in_recv");
        check_status("start_in_recv");

        // restart from DONE with a one-word program
        pulse_start();
        chk("restart_done_clear", {31'd0, o_done}, 32'd0);
        send_word(32'hFC000000, 1);
        drain("restart");
        check_status("restart");

        // overflow: 32 non-HALT words, the 33rd is ignored
        pulse_start();
        for (int i = 0; i < 32; i++) send_word(32'h00000000, 1);
        send_word(rand_nonhalt(), 0);
        drain("overflow");
        check_status("overflow");

        // random programs, some restarting from ERROR
        for (int it = 0; it < 8; it++) begin
            int nw;
            nw = $urandom_range(7, 0);
            pulse_start();
            for (int i = 0; i < nw; i++) send_word(rand_nonhalt(), 2);
            send_word(rand_halt(), 2);
            drain("random");
            check_status("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
